smc_req_arbiter6: RTL and testbench
===================================

# smc_req_arbiter6

Two-port request arbiter and transfer sequencer in front of the static memory controller's AHB-lite slave port. It accepts simple request/acknowledge transactions from two on-chip requesters (A and B). Each winning request is turned into a single NONSEQ AHB transfer on the SMC's haddr6/htrans6/hsel6/hwrite6/hsize6/hwdata6/hready6 inputs. The read data and response are returned to the owning requester. Misaligned requests are rejected locally without touching the SMC.

## Interface
- No parameters. Requester count is fixed at 2 and data width at 32.
- hclk6  in  1  clock; all logic on its rising edge.
- n_sys_reset6  in  1  asynchronous reset, active-low.
- prio_mode6  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority with A highest.
- a_req6 / b_req6  in  1  request; held high until the matching ack.
- a_addr6 / b_addr6  in  32  byte address.
- a_wr6 / b_wr6  in  1  1 = write, 0 = read.
- a_size6 / b_size6  in  3  AHB hsize encoding.
- a_wdata6 / b_wdata6  in  32  write data.
- a_ack6 / b_ack6  out  1  one-cycle completion pulse.
- a_rdata6 / b_rdata6  out  32  read data, valid while the ack is high.
- a_err6 / b_err6  out  1  error flag, valid while the ack is high.
- haddr6  out  32  AHB address to the SMC.
- htrans6  out  2  AHB transfer type: 00 IDLE or 10 NONSEQ only.
- hsel6  out  1  SMC select.
- hwrite6  out  1  AHB write indication.
- hsize6  out  3  AHB transfer size.
- hwdata6  out  32  AHB write data.
- hready6  out  1  muxed bus ready fed to the SMC.
- smc_hready6  in  1  SMC ready.
- smc_hrdata6  in  32  SMC read data.
- smc_hresp6  in  2  SMC response: 00 OKAY, 01 ERROR.
- grant6  out  2  one-hot current owner, {B,A}; 00 when idle.
- arb_busy6  out  1  high whenever the FSM is not in IDLE.

## Operation
- The FSM has four states: IDLE, ADDR, DATA, REJ.
- IDLE
  - Eligible requests are (a_req6 & ~a_ack6) and (b_req6 & ~b_ack6). A requester's own ack cycle is therefore never re-arbitrated.
  - Arbitration when prio_mode6=0 (round-robin): a single requester always wins. If both request, the one not recorded in last_grant wins.
  - Arbitration when prio_mode6=1: A wins whenever a_req6 is eligible.
  - On a win, the winner's addr/wr/size/wdata are latched, grant6 is set, and last_grant is updated.
  - A misaligned winner goes to REJ; an aligned winner goes to ADDR.
- Misaligned means any of:
  - size > 3'b010;
  - size 010 with addr[1:0] != 0;
  - size 001 with addr[0] != 0.
- ADDR
  - Outputs: htrans6=10, hsel6=1, haddr6/hwrite6/hsize6 from the latch, hready6=1.
  - Always lasts exactly one cycle, then goes to DATA.
- DATA
  - Outputs: htrans6=00, hsel6=0, hwdata6 from the latched wdata. hready6 = smc_hready6, passed through combinationally.
  - Stays in DATA while smc_hready6=0.
  - When smc_hready6=1: the owner's rdata is registered from smc_hrdata6 (reads with OKAY response only; otherwise it holds its previous value). The owner's err is registered as (smc_hresp6==01). The owner's ack is registered high. The FSM returns to IDLE.
  - The two-cycle ERROR response therefore needs no extra state.
- REJ
  - Lasts one cycle with no AHB transfer driven.
  - Then the owner's ack is pulsed with err=1 and rdata is unchanged. The FSM returns to IDLE.
- Ack, err and rdata are registered. The ack pulse lands in the cycle after leaving DATA or REJ, which is the first IDLE cycle.
- In IDLE, haddr6/hwrite6/hsize6 hold their last values. htrans6=00, hsel6=0, hready6=1.
- grant6 is high from the ADDR or REJ cycle through the ack cycle, then returns to 00 unless a new win happens.
- Reset values (also applied immediately on asynchronous assertion mid-transfer):
  - haddr6, hwdata6, and both rdata outputs: 0.
  - htrans6=00, hsel6=0, hwrite6=0, hsize6=000, hready6=1.
  - Both acks and both errs: 0. grant6=00. arb_busy6=0.
  - last_grant=B, so A wins the first tie.
  - Any in-flight transfer is dropped and no ack is issued.

## Timing
- Request sampled at edge 0 → ADDR during cycle 1 → DATA during cycle 2.
- With a zero-wait SMC, the ack is high in cycle 3. Each SMC wait state adds one cycle.
- Misaligned request: REJ in cycle 1, ack in cycle 2.
- A requester holding req through its ack is treated as a new request in the cycle after the ack. Minimum issue interval is 3 cycles per zero-wait transfer.

## Test plan
- **Zero-wait write:** A writes 0xDEADBEEF to 0x0000_0010, size 010.
  - ADDR cycle: haddr6=0x10, htrans6=10, hwrite6=1.
  - Next cycle: hwdata6=0xDEADBEEF.
  - a_ack6=1 and a_err6=0 in cycle 3.
- **Read with wait states:** B reads 0x0000_0100. SMC holds smc_hready6 low for 3 cycles, then returns 0x12345678.
  - DATA lasts 4 cycles and hready6 tracks smc_hready6.
  - b_rdata6=0x12345678 with b_ack6 in cycle 6.
- **Round-robin vs fixed priority:** both requests held continuously for 4 transfers.
  - prio_mode6=0: grant order A,B,A,B.
  - prio_mode6=1: grant order A,A,A,A; B is never granted while a_req6 stays high.
- **SMC error response:** smc_hresp6=01 with smc_hready6=0, then 01 with smc_hready6=1.
  - a_ack6=1 with a_err6=1.
  - a_rdata6 keeps its previous value.
- **Local reject:** A requests size 010 at 0x0000_0002.
  - htrans6 stays 00 throughout.
  - a_ack6=1 and a_err6=1 in cycle 2.
- **Reset mid-operation:** n_sys_reset6 is driven low during DATA.
  - All outputs take their reset values within the same cycle; no ack is ever issued.
  - After release, with both requests asserted, A is granted first.

Source files
------------

// File: rtl/smc_req_arbiter6.sv
// Two-port request arbiter that issues single NONSEQ AHB transfers to the SMC.
// Misaligned requests are rejected locally with an error ack.
module smc_req_arbiter6 (
  input  logic        hclk6,
  input  logic        n_sys_reset6,
  input  logic        prio_mode6,
  input  logic        a_req6,
  input  logic [31:0] a_addr6,
  input  logic        a_wr6,
  input  logic [2:0]  a_size6,
  input  logic [31:0] a_wdata6,
  output logic        a_ack6,
  output logic [31:0] a_rdata6,
  output logic        a_err6,
  input  logic        b_req6,
  input  logic [31:0] b_addr6,
  input  logic        b_wr6,
  input  logic [2:0]  b_size6,
  input  logic [31:0] b_wdata6,
  output logic        b_ack6,
  output logic [31:0] b_rdata6,
  output logic        b_err6,
  output logic [31:0] haddr6,
  output logic [1:0]  htrans6,
  output logic        hsel6,
  output logic        hwrite6,
  output logic [2:0]  hsize6,
  output logic [31:0] hwdata6,
  output logic        hready6,
  input  logic        smc_hready6,
  input  logic [31:0] smc_hrdata6,
  input  logic [1:0]  smc_hresp6,
  output logic [1:0]  grant6,
  output logic        arb_busy6
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REJ
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [2:0]  size_q, size_d;
  logic        own_q, own_d;
  logic        last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        a_err_q, a_err_d;
  logic        b_err_q, b_err_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  logic        a_elig, b_elig;
  logic        win_a, win_b;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic        sel_mis;
  logic        resp_err;

  assign a_elig   = a_req6 & ~a_ack_q;
  assign b_elig   = b_req6 & ~b_ack_q;
  assign sel_addr = win_b ? b_addr6 : a_addr6;
  assign sel_size = win_b ? b_size6 : a_size6;
  assign resp_err = (smc_hresp6 == 2'b01);

  // Pick a winner; last_q=1 means B was granted last.
  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (prio_mode6) begin
      win_a = a_elig;
      win_b = b_elig & ~a_req6;
    end else begin
      win_a = a_elig & (~b_elig | last_q);
      win_b = b_elig & (~a_elig | ~last_q);
    end
  end

  // Alignment check on the winning request.
  always_comb begin
    sel_mis = 1'b0;
    unique case (1'b1)
      (sel_size > 3'd2):  sel_mis = 1'b1;
      (sel_size == 3'd2): sel_mis = (sel_addr[1:0] != 2'b00);
      (sel_size == 3'd1): sel_mis = sel_addr[0];
      default:            sel_mis = 1'b0;
    endcase
  end

  // Next-state, request latch and registered completion outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    size_d    = size_q;
    own_d     = own_q;
    last_d    = last_q;
    grant_d   = grant_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_err_d   = a_err_q;
    b_err_d   = b_err_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = 2'b00;
        if (win_a | win_b) begin
          addr_d  = sel_addr;
          size_d  = sel_size;
          wr_d    = win_b ? b_wr6 : a_wr6;
          wdata_d = win_b ? b_wdata6 : a_wdata6;
          own_d   = win_b;
          last_d  = win_b;
          grant_d = {win_b, win_a};
          state_d = sel_mis ? S_REJ : S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        if (smc_hready6) begin
          state_d = S_IDLE;
          if (own_q) begin
            b_ack_d = 1'b1;
            b_err_d = resp_err;
            if (!wr_q && smc_hresp6 == 2'b00)
              b_rdata_d = smc_hrdata6;
          end else begin
            a_ack_d = 1'b1;
            a_err_d = resp_err;
            if (!wr_q && smc_hresp6 == 2'b00)
              a_rdata_d = smc_hrdata6;
          end
        end
      end
      S_REJ: begin
        state_d = S_IDLE;
        if (own_q) begin
          b_ack_d = 1'b1;
          b_err_d = 1'b1;
        end else begin
          a_ack_d = 1'b1;
          a_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; last_q resets to B so A wins the first tie.
  always_ff @(posedge hclk6 or negedge n_sys_reset6) begin
    if (!n_sys_reset6) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      size_q    <= 3'b000;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      own_q     <= own_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign haddr6    = addr_q;
  assign hwrite6   = wr_q;
  assign hsize6    = size_q;
  assign hwdata6   = wdata_q;
  assign htrans6   = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign hsel6     = (state_q == S_ADDR);
  assign hready6   = (state_q == S_DATA) ? smc_hready6 : 1'b1;
  assign grant6    = grant_q;
  assign arb_busy6 = (state_q != S_IDLE);
  assign a_ack6    = a_ack_q;
  assign b_ack6    = b_ack_q;
  assign a_err6    = a_err_q;
  assign b_err6    = b_err_q;
  assign a_rdata6  = a_rdata_q;
  assign b_rdata6  = b_rdata_q;

endmodule

// File: tb/tb_smc_req_arbiter6.sv
// Testbench for smc_req_arbiter6: directed steps plus random request pairs
// checked against a transaction-level model of arbitration and latency.
module tb_smc_req_arbiter6;

  logic        hclk6 = 1'b0;
  logic        n_sys_reset6;
  logic        prio_mode6;
  logic        a_req6, b_req6;
  logic [31:0] a_addr6, b_addr6;
  logic        a_wr6, b_wr6;
  logic [2:0]  a_size6, b_size6;
  logic [31:0] a_wdata6, b_wdata6;
  logic        a_ack6, b_ack6;
  logic [31:0] a_rdata6, b_rdata6;
  logic        a_err6, b_err6;
  logic [31:0] haddr6;
  logic [1:0]  htrans6;
  logic        hsel6, hwrite6;
  logic [2:0]  hsize6;
  logic [31:0] hwdata6;
  logic        hready6;
  logic        smc_hready6;
  logic [31:0] smc_hrdata6;
  logic [1:0]  smc_hresp6;
  logic [1:0]  grant6;
  logic        arb_busy6;

  always #5 hclk6 = ~hclk6;

  smc_req_arbiter6 dut (
    .hclk6(hclk6), .n_sys_reset6(n_sys_reset6), .prio_mode6(prio_mode6),
    .a_req6(a_req6), .a_addr6(a_addr6), .a_wr6(a_wr6), .a_size6(a_size6),
    .a_wdata6(a_wdata6), .a_ack6(a_ack6), .a_rdata6(a_rdata6), .a_err6(a_err6),
    .b_req6(b_req6), .b_addr6(b_addr6), .b_wr6(b_wr6), .b_size6(b_size6),
    .b_wdata6(b_wdata6), .b_ack6(b_ack6), .b_rdata6(b_rdata6), .b_err6(b_err6),
    .haddr6(haddr6), .htrans6(htrans6), .hsel6(hsel6), .hwrite6(hwrite6),
    .hsize6(hsize6), .hwdata6(hwdata6), .hready6(hready6),
    .smc_hready6(smc_hready6), .smc_hrdata6(smc_hrdata6),
    .smc_hresp6(smc_hresp6), .grant6(grant6), .arb_busy6(arb_busy6)
  );

  int checks = 0;
  int errors = 0;

  int          m_last;
  logic [31:0] m_rdata [2];

  logic [31:0] p_addr  [2];
  logic        p_wr    [2];
  logic [2:0]  p_size  [2];
  logic [31:0] p_wdata [2];
  int          p_wait  [2];
  logic        p_err   [2];
  logic [31:0] p_hrd   [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tk();
    @(posedge hclk6);
    #1;
  endtask

  function automatic bit mis(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    return (a % (32'd1 << s)) != 32'd0;
  endfunction

  task automatic drive_fields();
    a_addr6 = p_addr[0]; a_wr6 = p_wr[0];
    a_size6 = p_size[0]; a_wdata6 = p_wdata[0];
    b_addr6 = p_addr[1]; b_wr6 = p_wr[1];
    b_size6 = p_size[1]; b_wdata6 = p_wdata[1];
  endtask

  // One or two concurrent requests, served to completion.
  task automatic pair(input logic [1:0] mask, input logic mode);
    int first, second, own, ph, j, cw, maxc;
    int lat [2];
    int ex  [2];
    int q [$];
    logic        e_err;
    logic [31:0] e_rd;
    for (int i = 0; i < 2; i++) begin
      lat[i] = mis(p_addr[i], p_size[i]) ? 2 : 3 + p_wait[i];
      ex[i]  = -1;
    end
    if (mask == 2'b11) begin
      first  = mode ? 0 : (m_last == 1 ? 0 : 1);
      second = 1 - first;
      ex[first]  = lat[first];
      ex[second] = lat[first] + lat[second];
    end else begin
      first  = mask[1] ? 1 : 0;
      second = -1;
      ex[first] = lat[first];
    end
    if (!mis(p_addr[first], p_size[first])) q.push_back(first);
    if (second >= 0 && !mis(p_addr[second], p_size[second]))
      q.push_back(second);
    maxc = (ex[0] > ex[1] ? ex[0] : ex[1]) + 1;
    drive_fields();
    prio_mode6  = mode;
    smc_hready6 = 1'b1;
    smc_hresp6  = 2'b00;
    a_req6 = mask[0];
    b_req6 = mask[1];
    ph = 0; j = 0; cw = 0;
    for (int c = 1; c <= maxc; c++) begin
      tk();
      if (ph == 2) begin
        if (smc_hready6) ph = 0;
        else begin
          j++;
          smc_hready6 = (j == cw);
        end
      end else if (ph == 1) begin
        ph = 2;
        j  = 0;
      end
      chk("ack_a", 32'(a_ack6), 32'(c == ex[0]));
      chk("ack_b", 32'(b_ack6), 32'(c == ex[1]));
      for (int i = 0; i < 2; i++) begin
        if (c == ex[i]) begin
          if (mis(p_addr[i], p_size[i])) begin
            e_err = 1'b1;
            e_rd  = m_rdata[i];
          end else begin
            e_err = p_err[i];
            e_rd  = (!p_wr[i] && !p_err[i]) ? p_hrd[i] : m_rdata[i];
          end
          m_rdata[i] = e_rd;
          if (i == 0) begin
            chk("err_a", 32'(a_err6), 32'(e_err));
            chk("rdata_a", a_rdata6, e_rd);
            a_req6 = 1'b0;
          end else begin
            chk("err_b", 32'(b_err6), 32'(e_err));
            chk("rdata_b", b_rdata6, e_rd);
            b_req6 = 1'b0;
          end
        end
      end
      if (htrans6 == 2'b10 && q.size() > 0) begin
        own = q.pop_front();
        chk("haddr", haddr6, p_addr[own]);
        chk("grant", 32'(grant6), own == 1 ? 32'd2 : 32'd1);
        chk("hwrite", 32'(hwrite6), 32'(p_wr[own]));
        cw = p_wait[own];
        ph = 1;
        smc_hready6 = (cw == 0);
        smc_hrdata6 = p_hrd[own];
        smc_hresp6  = p_err[own] ? 2'b01 : 2'b00;
      end
    end
    a_req6 = 1'b0;
    b_req6 = 1'b0;
    m_last = (second >= 0) ? second : first;
  endtask

  logic [1:0] g [4];
  int         n, acks, backs;
  logic [1:0] rmask;
  logic       rmode;

  initial begin
    n_sys_reset6 = 1'b0;
    prio_mode6 = 1'b0;
    a_req6 = 1'b0; b_req6 = 1'b0;
    a_addr6 = '0; b_addr6 = '0;
    a_wr6 = 1'b0; b_wr6 = 1'b0;
    a_size6 = '0; b_size6 = '0;
    a_wdata6 = '0; b_wdata6 = '0;
    smc_hready6 = 1'b1;
    smc_hrdata6 = '0;
    smc_hresp6 = 2'b00;
    m_last = 1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;

    tk(); tk();
    chk("rst_htrans", 32'(htrans6), 32'd0);
    chk("rst_hsel", 32'(hsel6), 32'd0);
    chk("rst_hready", 32'(hready6), 32'd1);
    chk("rst_grant", 32'(grant6), 32'd0);
    chk("rst_busy", 32'(arb_busy6), 32'd0);
    chk("rst_haddr", haddr6, 32'd0);
    chk("rst_hwdata", hwdata6, 32'd0);
    chk("rst_acks", 32'({a_ack6, b_ack6, a_err6, b_err6}), 32'd0);
    chk("rst_rdata", a_rdata6 | b_rdata6, 32'd0);
    n_sys_reset6 = 1'b1;
    tk();

    // zero-wait write from A
    a_addr6 = 32'h10; a_wr6 = 1'b1; a_size6 = 3'd2;
    a_wdata6 = 32'hDEADBEEF; a_req6 = 1'b1;
    tk();
    chk("w_htrans", 32'(htrans6), 32'd2);
    chk("w_haddr", haddr6, 32'h10);
    chk("w_hwrite", 32'(hwrite6), 32'd1);
    chk("w_hsel", 32'(hsel6), 32'd1);
    chk("w_hsize", 32'(hsize6), 32'd2);
    chk("w_grant", 32'(grant6), 32'd1);
    chk("w_busy", 32'(arb_busy6), 32'd1);
    tk();
    chk("w_hwdata", hwdata6, 32'hDEADBEEF);
    chk("w_htrans2", 32'(htrans6), 32'd0);
    chk("w_ack2", 32'(a_ack6), 32'd0);
    tk();
    chk("w_ack3", 32'(a_ack6), 32'd1);
    chk("w_err3", 32'(a_err6), 32'd0);
    chk("w_grant3", 32'(grant6), 32'd1);
    a_req6 = 1'b0;
    tk();
    chk("w_ack4", 32'(a_ack6), 32'd0);
    chk("w_grant4", 32'(grant6), 32'd0);
    chk("w_busy4", 32'(arb_busy6), 32'd0);
    m_last = 0;

    // read from B with three wait states
    b_addr6 = 32'h100; b_wr6 = 1'b0; b_size6 = 3'd2; b_req6 = 1'b1;
    smc_hready6 = 1'b0;
    smc_hrdata6 = 32'h12345678;
    tk();
    chk("r_haddr", haddr6, 32'h100);
    chk("r_hwrite", 32'(hwrite6), 32'd0);
    chk("r_grant", 32'(grant6), 32'd2);
    for (int c = 2; c <= 5; c++) begin
      tk();
      smc_hready6 = (c == 5);
      #1;
      chk("r_hready", 32'(hready6), 32'(c == 5));
      chk("r_busy", 32'(arb_busy6), 32'd1);
      chk("r_noack", 32'(b_ack6), 32'd0);
    end
    tk();
    chk("r_ack", 32'(b_ack6), 32'd1);
    chk("r_rdata", b_rdata6, 32'h12345678);
    chk("r_err", 32'(b_err6), 32'd0);
    b_req6 = 1'b0;
    m_last = 1;
    m_rdata[1] = 32'h12345678;
    smc_hready6 = 1'b1;
    tk();

    // round-robin, then fixed priority, with both requests held
    for (int m = 0; m < 2; m++) begin
      prio_mode6 = m[0];
      a_addr6 = 32'h40; a_wr6 = 1'b1; a_size6 = 3'd2;
      b_addr6 = 32'h80; b_wr6 = 1'b1; b_size6 = 3'd2;
      a_req6 = 1'b1; b_req6 = 1'b1;
      n = 0; acks = 0; backs = 0;
      for (int c = 0; c < 40 && acks < 4; c++) begin
        tk();
        if (htrans6 == 2'b10 && n < 4) begin
          g[n] = grant6;
          n++;
        end
        if (a_ack6 || b_ack6) acks++;
        if (b_ack6) backs++;
        if (acks == 4) begin
          a_req6 = 1'b0;
          b_req6 = 1'b0;
        end
      end
      a_req6 = 1'b0;
      b_req6 = 1'b0;
      chk(m == 0 ? "rr_acks" : "fp_acks", 32'(acks), 32'd4);
      for (int i = 0; i < 4; i++)
        chk(m == 0 ? "rr_order" : "fp_order", 32'(g[i]),
            (m == 0 && i[0]) ? 32'd2 : 32'd1);
      if (m == 1) chk("fp_no_b", 32'(backs), 32'd0);
      tk();
    end
    m_last = 0;

    // OKAY read then an ERROR response that must not touch rdata
    p_addr[0] = 32'h20; p_wr[0] = 1'b0; p_size[0] = 3'd2;
    p_wdata[0] = '0; p_wait[0] = 0; p_err[0] = 1'b0;
    p_hrd[0] = 32'hCAFEF00D;
    p_addr[1] = '0; p_wr[1] = 1'b0; p_size[1] = 3'd0;
    p_wdata[1] = '0; p_wait[1] = 0; p_err[1] = 1'b0; p_hrd[1] = '0;
    pair(2'b01, 1'b0);
    p_wait[0] = 1; p_err[0] = 1'b1; p_hrd[0] = 32'hBAD0BAD0;
    pair(2'b01, 1'b0);
    chk("e_keep", a_rdata6, 32'hCAFEF00D);
    tk();

    // local reject of a misaligned word access
    prio_mode6 = 1'b0;
    a_addr6 = 32'h2; a_wr6 = 1'b0; a_size6 = 3'd2; a_req6 = 1'b1;
    tk();
    chk("j_htrans1", 32'(htrans6), 32'd0);
    chk("j_hsel1", 32'(hsel6), 32'd0);
    chk("j_grant1", 32'(grant6), 32'd1);
    chk("j_busy1", 32'(arb_busy6), 32'd1);
    tk();
    chk("j_htrans2", 32'(htrans6), 32'd0);
    chk("j_ack", 32'(a_ack6), 32'd1);
    chk("j_err", 32'(a_err6), 32'd1);
    chk("j_rdata", a_rdata6, m_rdata[0]);
    a_req6 = 1'b0;
    tk();
    chk("j_ack_off", 32'(a_ack6), 32'd0);
    m_last = 0;

    // asynchronous reset in the middle of a DATA phase
    a_addr6 = 32'h200; a_wr6 = 1'b0; a_size6 = 3'd2; a_req6 = 1'b1;
    smc_hready6 = 1'b0;
    tk();
    tk();
    b_addr6 = 32'h300; b_wr6 = 1'b0; b_size6 = 3'd2; b_req6 = 1'b1;
    n_sys_reset6 = 1'b0;
    #1;
    chk("x_htrans", 32'(htrans6), 32'd0);
    chk("x_hsel", 32'(hsel6), 32'd0);
    chk("x_hready", 32'(hready6), 32'd1);
    chk("x_grant", 32'(grant6), 32'd0);
    chk("x_busy", 32'(arb_busy6), 32'd0);
    chk("x_haddr", haddr6, 32'd0);
    chk("x_hctl", 32'({hwrite6, hsize6}), 32'd0);
    chk("x_rdata", a_rdata6 | b_rdata6, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tk();
      chk("x_noack", 32'({a_ack6, b_ack6}), 32'd0);
    end
    smc_hready6 = 1'b1;
    n_sys_reset6 = 1'b1;
    tk();
    chk("x_first", 32'(grant6), 32'd1);
    chk("x_first_tr", 32'(htrans6), 32'd2);
    a_req6 = 1'b0;
    b_req6 = 1'b0;
    n_sys_reset6 = 1'b0;
    tk();
    n_sys_reset6 = 1'b1;
    tk();
    m_last = 1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;

    // random request pairs against the transaction model
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 2; i++) begin
        p_size[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                : 3'($urandom_range(0, 2));
        p_addr[i] = {$urandom_range(0, 32'hFFFF), 16'h0} |
                    32'($urandom_range(0, 15));
        p_wr[i]    = 1'($urandom_range(0, 1));
        p_wdata[i] = $urandom;
        p_wait[i]  = $urandom_range(0, 3);
        p_err[i]   = ($urandom_range(0, 3) == 0);
        p_hrd[i]   = $urandom;
      end
      rmask = 2'($urandom_range(1, 3));
      rmode = 1'($urandom_range(0, 1));
      pair(rmask, rmode);
      tk();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
